// File: rtl/apb_pkg.sv
// Shared APB definitions: bridge state encoding, data width, PWM controller
// register map and the read pattern the PWM controller returns on a bad index.
package apb_pkg;

  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  // PWM controller register offsets (word aligned, 6-bit address space)
  localparam logic [5:0] PWM_CTRL_STATUS    = 6'h00;
  localparam logic [5:0] PWM_T1_DUTY        = 6'h04;
  localparam logic [5:0] PWM_T1_PULSE_COUNT = 6'h08;
  localparam logic [5:0] PWM_T2_DUTY        = 6'h0C;
  localparam logic [5:0] PWM_T2_PULSE_COUNT = 6'h10;
  localparam logic [5:0] PWM_T3_DUTY        = 6'h14;
  localparam logic [5:0] PWM_T3_PULSE_COUNT = 6'h18;
  localparam int         PWM_NUM_REGS       = 7;

  localparam logic [APB_DATA_W-1:0] ERR_RDATA = 32'hDEADBEEF;

  function automatic logic addr_aligned(input logic [1:0] lsbs);
    return lsbs == 2'b00;
  endfunction

endpackage

// File: rtl/apb_master_bridge.sv
// Request/response stream to APB3 initiator: one outstanding transfer,
// ACCESS-phase timeout and local rejection of unaligned addresses.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // Handshakes: a beat transfers on the rising edge where valid and ready are
  // both high; valid never waits on ready, and payload is held while valid.
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              rsp_timeout_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i,
  input  logic              pslverr_i,
  output logic              busy_o,
  output apb_state_e        state_o
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  apb_state_e       state;
  logic [CNT_W-1:0] tmo_cnt;
  logic             req_hs;
  logic             expired;

  // Ready is gated by reset so it reads 0 while rst_i is held and 1 as soon
  // as it is released, without waiting for a clock edge.
  assign req_ready_o = (state == ST_IDLE) && !rst_i;
  assign req_hs      = req_valid_i && req_ready_o;
  assign expired     = (TIMEOUT > 0) && (tmo_cnt == CNT_LAST);
  assign busy_o      = (state != ST_IDLE);
  assign state_o     = state;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= ST_IDLE;
      tmo_cnt       <= '0;
      psel_o        <= 1'b0;
      penable_o     <= 1'b0;
      pwrite_o      <= 1'b0;
      paddr_o       <= '0;
      pwdata_o      <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_hs) begin
            if (!addr_aligned(req_addr_i[1:0])) begin
              state         <= ST_RESP;
              rsp_valid_o   <= 1'b1;
              rsp_err_o     <= 1'b1;
              rsp_timeout_o <= 1'b0;
              rsp_rdata_o   <= '0;
            end else begin
              state    <= ST_SETUP;
              tmo_cnt  <= '0;
              psel_o   <= 1'b1;
              pwrite_o <= req_write_i;
              paddr_o  <= req_addr_i;
              pwdata_o <= req_write_i ? req_wdata_i : '0;
            end
          end
        end
        ST_SETUP: begin
          state     <= ST_ACCESS;
          penable_o <= 1'b1;
        end
        ST_ACCESS: begin
          // pready beats an expiry landing in the same cycle
          if (pready_i) begin
            state         <= ST_RESP;
            psel_o        <= 1'b0;
            penable_o     <= 1'b0;
            rsp_valid_o   <= 1'b1;
            rsp_err_o     <= pslverr_i;
            rsp_timeout_o <= 1'b0;
            rsp_rdata_o   <= pwrite_o ? '0 : prdata_i;
          end else if (expired) begin
            state         <= ST_RESP;
            psel_o        <= 1'b0;
            penable_o     <= 1'b0;
            rsp_valid_o   <= 1'b1;
            rsp_err_o     <= 1'b1;
            rsp_timeout_o <= 1'b1;
            rsp_rdata_o   <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            state       <= ST_IDLE;
            rsp_valid_o <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: a PWM-like APB responder with programmable wait
// states, a transaction-level reference model and a per-cycle compare process.
`timescale 1ns/1ps
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;
  localparam int NEVER   = 1000;
  localparam int REQ_W   = 1 + ADDR_W + DATA_W + 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // ---------------- DUT (TIMEOUT=16) ----------------
  logic              req_valid = 0, req_write = 0, rsp_ready = 0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              req_ready, rsp_valid, rsp_err, rsp_timeout;
  logic [DATA_W-1:0] rsp_rdata;
  logic              psel, penable, pwrite, busy;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata = '0;
  logic              pready = 0, pslverr = 0;
  apb_state_e        state;

  apb_master_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
    .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .paddr_o(paddr),
    .pwdata_o(pwdata), .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr),
    .busy_o(busy), .state_o(state)
  );

  // ---------------- second DUT with timeout disabled ----------------
  logic              req_valid0 = 0, req_write0 = 0, rsp_ready0 = 0;
  logic [ADDR_W-1:0] req_addr0 = '0;
  logic [DATA_W-1:0] req_wdata0 = '0;
  logic              req_ready0, rsp_valid0, rsp_err0, rsp_timeout0;
  logic [DATA_W-1:0] rsp_rdata0;
  logic              psel0, penable0, pwrite0, busy0;
  logic [ADDR_W-1:0] paddr0;
  logic [DATA_W-1:0] pwdata0;
  logic [DATA_W-1:0] prdata0 = '0;
  logic              pready0 = 0, pslverr0 = 0;
  apb_state_e        state0;

  apb_master_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(0)) dut0 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid0), .req_ready_o(req_ready0), .req_write_i(req_write0),
    .req_addr_i(req_addr0), .req_wdata_i(req_wdata0),
    .rsp_valid_o(rsp_valid0), .rsp_ready_i(rsp_ready0), .rsp_rdata_o(rsp_rdata0),
    .rsp_err_o(rsp_err0), .rsp_timeout_o(rsp_timeout0),
    .psel_o(psel0), .penable_o(penable0), .pwrite_o(pwrite0), .paddr_o(paddr0),
    .pwdata_o(pwdata0), .prdata_i(prdata0), .pready_i(pready0), .pslverr_i(pslverr0),
    .busy_o(busy0), .state_o(state0)
  );

  // ---------------- check bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s bound expired at %0t", name, $time);
  endtask

  // ---------------- APB responder (PWM-like register file) ----------------
  // Raises pready on ACCESS cycle number rsp_wait (0 = zero-wait). Indices
  // above 6 answer with pslverr and the error pattern.
  logic [DATA_W-1:0] rsp_mem [PWM_NUM_REGS] = '{default: '0};
  int rsp_wait = 0;
  int acc_n    = 0;

  always @(posedge clk) begin
    int ri;
    #1;
    if (rst) begin
      acc_n  = 0;
      pready = 0;
    end else if (psel && penable) begin
      ri = int'(paddr >> 2);
      if (acc_n == rsp_wait) begin
        pready  = 1;
        pslverr = (ri >= PWM_NUM_REGS);
        if (ri >= PWM_NUM_REGS) prdata = ERR_RDATA;
        else if (pwrite)        prdata = $urandom;
        else                    prdata = rsp_mem[ri];
        if (pwrite && ri < PWM_NUM_REGS) rsp_mem[ri] = pwdata;
      end else begin
        pready  = 0;
        pslverr = 1'($urandom_range(0, 1));
        prdata  = $urandom;
      end
      acc_n++;
    end else begin
      pready  = 0;
      pslverr = 0;
      prdata  = $urandom;
      acc_n   = 0;
    end
  end

  // ---------------- reference model + scoreboard ----------------
  logic [REQ_W-1:0]  exp_q[$];
  logic [DATA_W-1:0] mdl_mem [PWM_NUM_REGS] = '{default: '0};

  logic              in_flight = 0, acc_pend = 0, hs_pend = 0;
  int                cyc = 0, pen_seen = 0;
  logic              m_wr, m_aligned, m_to, m_err;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data, m_rdata;
  int                m_wait, m_npen, m_lat, m_idx;

  always @(negedge clk) begin
    logic [REQ_W-1:0] cur;
    logic e_psel, e_pen, e_rv;
    if (rst) begin
      in_flight = 0;
      acc_pend  = 0;
      hs_pend   = 0;
      exp_q.delete();
    end else begin
      if (hs_pend) begin
        in_flight = 0;
        hs_pend   = 0;
      end
      if (acc_pend) begin
        acc_pend = 0;
        if (exp_q.size() == 0) begin
          fail("spurious_accept");
        end else begin
          cur = exp_q.pop_front();
          {m_wr, m_addr, m_data} = cur[REQ_W-1:16];
          m_wait    = int'(cur[15:0]);
          m_aligned = (m_addr[1:0] == 2'b00);
          m_idx     = int'(m_addr >> 2);
          if (!m_aligned) begin
            m_to = 0; m_err = 1; m_rdata = '0; m_npen = 0; m_lat = 1;
          end else begin
            m_to   = (TIMEOUT > 0) && (m_wait >= TIMEOUT);
            m_npen = m_to ? TIMEOUT : m_wait + 1;
            m_lat  = m_npen + 2;
            m_err  = m_to || (m_idx >= PWM_NUM_REGS);
            if (m_to || m_wr)                m_rdata = '0;
            else if (m_idx >= PWM_NUM_REGS)  m_rdata = ERR_RDATA;
            else                             m_rdata = mdl_mem[m_idx];
            if (!m_to && m_wr && m_idx < PWM_NUM_REGS) mdl_mem[m_idx] = m_data;
          end
          in_flight = 1;
          cyc       = 1;
          pen_seen  = 0;
        end
      end else if (in_flight) begin
        cyc++;
      end
      if (in_flight && penable) pen_seen++;

      e_psel = in_flight && m_aligned && (cyc <= m_npen + 1);
      e_pen  = in_flight && m_aligned && (cyc >= 2) && (cyc <= m_npen + 1);
      e_rv   = in_flight && (cyc >= m_lat);

      chk("req_ready", req_ready, !in_flight);
      chk("busy", busy, in_flight);
      chk("state_idle", state == ST_IDLE, !in_flight);
      chk("psel", psel, e_psel);
      chk("penable", penable, e_pen);
      chk("rsp_valid", rsp_valid, e_rv);
      if (e_rv) begin
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rsp_err", rsp_err, m_err);
        chk("rsp_timeout", rsp_timeout, m_to);
      end
      if (e_psel) begin
        chk("paddr", paddr, m_addr);
        chk("pwrite", pwrite, m_wr);
        chk("pwdata", pwdata, m_wr ? m_data : '0);
      end

      if (req_valid && req_ready) acc_pend = 1;
      if (rsp_valid && rsp_ready) hs_pend = 1;
    end
  end

  // ---------------- driver tasks ----------------
  int unsigned acc_cyc = 0;

  task automatic issue_req(input logic wr, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] data, input int w);
    int n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) fail("req_ready_wait");
    rsp_wait = w;
    exp_q.push_back({wr, addr, data, 16'(w)});
    req_valid = 1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = data;
    @(posedge clk); #1;
    acc_cyc   = cyc_cnt;
    req_valid = 0;
    req_write = 1'($urandom);
    req_addr  = ADDR_W'($urandom);
    req_wdata = $urandom;
  endtask

  task automatic get_rsp(input int stall, output logic [DATA_W-1:0] rd,
                         output logic er, output logic to, output int lat);
    int n = 0;
    while (!rsp_valid && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (!rsp_valid) begin
      fail("rsp_valid_wait");
      rd = '0; er = 0; to = 0; lat = -1;
      return;
    end
    lat = int'(cyc_cnt - acc_cyc) + 1;
    rd  = rsp_rdata;
    er  = rsp_err;
    to  = rsp_timeout;
    repeat (stall) begin
      @(posedge clk); #1;
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
  endtask

  task automatic send(input logic wr, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] data, input int w, input int stall,
                      output logic [DATA_W-1:0] rd, output logic er,
                      output logic to, output int lat);
    issue_req(wr, addr, data, w);
    get_rsp(stall, rd, er, to, lat);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [DATA_W-1:0] rd;
    logic              er, to;
    int                lat, w, sel, ok, n;
    logic [ADDR_W-1:0] a;

    #1 rst = 1;
    #2;
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    repeat (3) @(posedge clk);
    #2 rst = 0;
    #1 chk("req_ready_after_rst", req_ready, 1);
    @(posedge clk); #1;

    // PWM controller with registered pready: one wait state
    send(1, PWM_T1_DUTY, 32'd50, 1, 0, rd, er, to, lat);
    chk("wr04_lat", lat, 4);
    chk("wr04_err", er, 0);
    send(0, PWM_T1_DUTY, '0, 1, 0, rd, er, to, lat);
    chk("rd04_rdata", rd, 50);
    chk("rd04_lat", lat, 4);
    send(0, 6'h1C, '0, 1, 0, rd, er, to, lat);
    chk("rd1c_err", er, 1);
    chk("rd1c_rdata", rd, 32'hDEADBEEF);
    chk("rd1c_timeout", to, 0);

    // zero-wait responder
    send(1, PWM_T1_PULSE_COUNT, 32'hA5A5_0001, 0, 0, rd, er, to, lat);
    chk("zw_lat", lat, 3);

    // unaligned reject
    send(1, 6'h05, 32'h1111_2222, 0, 0, rd, er, to, lat);
    chk("unal_lat", lat, 1);
    chk("unal_err", er, 1);
    chk("unal_rdata", rd, 0);

    // timeout: responder never answers
    send(0, PWM_T2_DUTY, '0, NEVER, 0, rd, er, to, lat);
    chk("tmo_err", er, 1);
    chk("tmo_flag", to, 1);
    chk("tmo_rdata", rd, 0);
    chk("tmo_pen_cycles", pen_seen, 16);
    chk("tmo_lat", lat, 18);

    // pready on the last permitted ACCESS cycle beats the timeout
    send(0, PWM_T1_DUTY, '0, TIMEOUT - 1, 0, rd, er, to, lat);
    chk("edge_timeout", to, 0);
    chk("edge_rdata", rd, 50);
    chk("edge_pen_cycles", pen_seen, 16);

    // response stalled for 5 cycles
    send(0, PWM_T1_PULSE_COUNT, '0, 1, 5, rd, er, to, lat);
    chk("stall_rdata", rd, 32'hA5A5_0001);

    // reset in the middle of ACCESS drops the transfer
    issue_req(1, PWM_T2_PULSE_COUNT, 32'h0000_1234, NEVER);
    repeat (4) @(posedge clk);
    #2 rst = 1;
    #1;
    chk("midrst_psel", psel, 0);
    chk("midrst_penable", penable, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_req_ready", req_ready, 0);
    @(posedge clk);
    #2 rst = 0;
    @(posedge clk); #1;
    send(0, PWM_T2_PULSE_COUNT, '0, 0, 0, rd, er, to, lat);
    chk("post_rst_rdata", rd, 0);
    chk("post_rst_err", er, 0);

    // randomized traffic
    for (int t = 0; t < 80; t++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 3)      w = 0;
      else if (sel <= 6) w = 1;
      else if (sel == 7) w = $urandom_range(2, 5);
      else if (sel == 8) w = TIMEOUT - 1;
      else               w = NEVER;
      if ($urandom_range(0, 7) == 0) a = {4'($urandom), 2'($urandom_range(1, 3))};
      else                           a = ADDR_W'($urandom_range(0, 9) << 2);
      send(1'($urandom), a, $urandom, w, $urandom_range(0, 3), rd, er, to, lat);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    // timeout disabled: ACCESS is held until pready arrives
    req_valid0 = 1; req_write0 = 1; req_addr0 = PWM_T3_DUTY; req_wdata0 = 32'h77;
    n = 0;
    while (!req_ready0 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    req_valid0 = 0;
    ok = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (psel0 && penable0 && !rsp_valid0) ok++;
    end
    chk("nto_hold", ok, 40);
    pready0 = 1;
    @(posedge clk); #1;
    pready0 = 0;
    chk("nto_rsp_valid", rsp_valid0, 1);
    chk("nto_err", rsp_err0, 0);
    chk("nto_timeout", rsp_timeout0, 0);
    rsp_ready0 = 1;
    @(posedge clk); #1;
    rsp_ready0 = 0;
    chk("nto_req_ready", req_ready0, 1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
